// File: rtl/flit_packetizer_pkg.sv
// Shared types for the flit packetizer: flit label enum, head/body data
// union, flit structs with and without a VC field, and default field widths.
package struct_param;

  localparam int X_DES_DEF     = 4;
  localparam int Y_DES_DEF     = 4;
  localparam int PAYLOAD_W_DEF = 32;
  localparam int HEAD_PL_W_DEF = PAYLOAD_W_DEF - X_DES_DEF - Y_DES_DEF;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_e;

  typedef struct packed {
    logic [X_DES_DEF-1:0]     x;
    logic [Y_DES_DEF-1:0]     y;
    logic [HEAD_PL_W_DEF-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head;
    logic [PAYLOAD_W_DEF-1:0]  body;
  } flit_data_u;

  typedef struct packed {
    flit_label_e label;
    flit_data_u  data;
  } flit_novc_t;

  typedef struct packed {
    flit_label_e label;
    logic [0:0]  vc;
    flit_data_u  data;
  } flit_vc_t;

  // Label of the flit currently on the output: head phase distinguishes a
  // single-flit packet, body phase marks the last payload flit as TAIL.
  function automatic flit_label_e label_decode(input logic head_phase,
                                               input logic is_zero,
                                               input logic is_last);
    flit_label_e lbl;
    if (head_phase) begin
      lbl = is_zero ? HEADTAIL : HEAD;
    end else begin
      lbl = is_last ? TAIL : BODY;
    end
    return lbl;
  endfunction

endpackage

// File: rtl/flit_len_counter.sv
// Remaining-flit counter for the packetizer. Loads a saturated length on
// request acceptance, counts down once per body transfer without wrapping,
// and decodes the output flit label.
module flit_len_counter
  import struct_param::*;
#(
  parameter  int MAX_BODY = 15,
  localparam int LEN_W    = $clog2(MAX_BODY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  input  logic             dec,
  input  logic             head_phase,
  output logic             is_last,
  output logic             is_zero,
  output flit_label_e      label
);

  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] max_len_s;
  logic [LEN_W-1:0] load_sat_s;

  // Clamp the requested length to the largest packet the counter supports.
  always_comb begin
    max_len_s = LEN_W'(MAX_BODY);
    if (load_len > max_len_s) begin
      load_sat_s = max_len_s;
    end else begin
      load_sat_s = load_len;
    end
  end

  // Load on acceptance, count down per body transfer, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_sat_s;
    end else if (dec && (cnt_r != {LEN_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Status flags and label decode from the current count.
  always_comb begin
    is_zero = (cnt_r == {LEN_W{1'b0}});
    is_last = (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1});
    label   = label_decode(head_phase, is_zero, is_last);
  end

endmodule

// File: rtl/flit_packetizer.sv
// Flit packetizer: accepts a routing request, emits a HEAD flit carrying
// {x, y, head_pl}, then passes req_len payload words through as BODY flits
// with the last one labelled TAIL. Zero-length requests yield one HEADTAIL.
// Optional macro FLIT_VC_EN: drive flit_vc from the latched req_vc;
// otherwise flit_vc is tied to zero.
module flit_packetizer
  import struct_param::*;
#(
  parameter  int X_DES     = 4,
  parameter  int Y_DES     = 4,
  parameter  int PAYLOAD_W = 32,
  parameter  int MAX_BODY  = 15,
  parameter  int NUM_VC    = 2,
  localparam int LEN_W     = $clog2(MAX_BODY + 1),
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int HPL_W     = PAYLOAD_W - X_DES - Y_DES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [X_DES-1:0]     req_x,
  input  logic [Y_DES-1:0]     req_y,
  input  logic [HPL_W-1:0]     req_head_pl,
  input  logic [LEN_W-1:0]     req_len,
  input  logic [VC_W-1:0]      req_vc,
  input  logic                 pl_valid,
  output logic                 pl_ready,
  input  logic [PAYLOAD_W-1:0] pl_data,
  output logic                 flit_valid,
  input  logic                 flit_ready,
  output flit_label_e          flit_label,
  output logic [PAYLOAD_W-1:0] flit_data,
  output logic [VC_W-1:0]      flit_vc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [X_DES-1:0] x_r;
  logic [Y_DES-1:0] y_r;
  logic [HPL_W-1:0] hpl_r;
  logic [VC_W-1:0]  vc_out_s;
  logic             accept_s;
  logic             body_xfer_s;
  logic             is_last_s;
  logic             is_zero_s;
  flit_label_e      cnt_label_s;

`ifdef FLIT_VC_EN
  logic [VC_W-1:0]  vc_r;
`else
  logic             unused_vc_s;
`endif

  assign accept_s    = req_valid && (state_r == S_IDLE);
  assign body_xfer_s = (state_r == S_BODY) && pl_valid && flit_ready;

  flit_len_counter #(
    .MAX_BODY (MAX_BODY)
  ) u_len_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept_s),
    .load_len   (req_len),
    .dec        (body_xfer_s),
    .head_phase (state_r != S_BODY),
    .is_last    (is_last_s),
    .is_zero    (is_zero_s),
    .label      (cnt_label_s)
  );

  // Capture the request fields when the request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= {X_DES{1'b0}};
      y_r   <= {Y_DES{1'b0}};
      hpl_r <= {HPL_W{1'b0}};
    end else if (accept_s) begin
      x_r   <= req_x;
      y_r   <= req_y;
      hpl_r <= req_head_pl;
    end else begin
      x_r   <= x_r;
      y_r   <= y_r;
      hpl_r <= hpl_r;
    end
  end

`ifdef FLIT_VC_EN
  // Capture the virtual channel alongside the other request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_r <= {VC_W{1'b0}};
    end else if (accept_s) begin
      vc_r <= req_vc;
    end else begin
      vc_r <= vc_r;
    end
  end

  assign vc_out_s = vc_r;
`else
  assign unused_vc_s = ^req_vc;
  assign vc_out_s    = {VC_W{1'b0}};
`endif

  // Packet sequencing: IDLE -> HEAD -> (BODY ->) IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt_s = S_HEAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HEAD: begin
        if (flit_ready) begin
          state_nxt_s = is_zero_s ? S_IDLE : S_BODY;
        end else begin
          state_nxt_s = S_HEAD;
        end
      end
      S_BODY: begin
        if (body_xfer_s && is_last_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_BODY;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output decode; the body phase is a zero-latency pass-through of the
  // payload stream, so backpressure flows straight back to the source.
  always_comb begin
    req_ready  = 1'b0;
    pl_ready   = 1'b0;
    flit_valid = 1'b0;
    flit_label = HEAD;
    flit_data  = {PAYLOAD_W{1'b0}};
    flit_vc    = {VC_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_HEAD: begin
        flit_valid = 1'b1;
        flit_label = cnt_label_s;
        flit_data  = {x_r, y_r, hpl_r};
        flit_vc    = vc_out_s;
      end
      S_BODY: begin
        flit_valid = pl_valid;
        pl_ready   = flit_ready;
        flit_label = cnt_label_s;
        flit_data  = pl_data;
        flit_vc    = vc_out_s;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule
